// File: rtl/xv.sv
// Shared renderer definitions: opcode field layout,
// execute opcode and command-queue sequencer states.
package xv;

  localparam int PR_OP_MSB = 15;
  localparam int PR_OP_LSB = 12;

  localparam logic [3:0] PR_EXECUTE = 4'hE;

  typedef enum logic [1:0] {
    ISSUE,
    HOLD,
    WAIT
  } prim_q_state_t;

endpackage

// File: rtl/sync_fifo_16.sv
// Single-clock circular FIFO with occupancy count.
// Storage has no reset so it can map onto LUT/block RAM.
module sync_fifo_16 #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = DEPTH[DEPTH_LOG2:0];

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full_o    = (count_o == CNT_FULL);
  assign empty_o   = (count_o == '0);
  assign rd_ok     = rd_en_i && !empty_o;
  assign wr_ok     = wr_en_i && (!full_o || rd_ok);
  assign rd_data_o = mem[rd_ptr];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data_i;
  end

  // Pointers wrap naturally; count tracks net occupancy.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_ok, rd_ok})
        2'b10:   count_o <= count_o + CNT_ONE;
        2'b01:   count_o <= count_o - CNT_ONE;
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/prim_cmd_queue.sv
// Buffered command front-end for the primitive renderer.
// Holds commands back while a primitive is being drawn.
module prim_cmd_queue
  import xv::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                wr_cmd_i,
  input  logic [15:0]         wr_data_i,
  output logic                full_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                overflow_o,
  input  logic                clr_ovf_i,
  output logic [15:0]         cmd_o,
  output logic                cmd_valid_o,
  input  logic                rndr_busy_i,
  input  logic                vram_grant_i,
  output logic                rndr_oe_o,
  output logic                idle_o
);

  localparam int CW = $clog2(HOLD_CYC + 1) < 1 ? 1 : $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_ONE = 1;
  localparam logic [CW-1:0] HOLD_INIT = HOLD_CYC[CW-1:0];

  prim_q_state_t state_q;
  prim_q_state_t state_d;
  logic [CW-1:0] hold_q;
  logic [CW-1:0] hold_d;
  logic [15:0]   head;
  logic          empty;
  logic          pop;
  logic          drop;

  sync_fifo_16 #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_fifo (
    .clk       (clk),
    .reset_i   (reset_i),
    .wr_en_i   (wr_cmd_i),
    .wr_data_i (wr_data_i),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count_o),
    .full_o    (full_o),
    .empty_o   (empty)
  );

  assign drop      = wr_cmd_i && full_o && !pop;
  assign rndr_oe_o = vram_grant_i;
  assign idle_o    = empty && (state_q == ISSUE) && !rndr_busy_i;

  // Sequencer: pop only in ISSUE, blind hold after execute,
  // then wait for the renderer to go idle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      ISSUE: begin
        if (!empty && !rndr_busy_i) begin
          pop = 1'b1;
          if (head[PR_OP_MSB:PR_OP_LSB] == PR_EXECUTE) begin
            state_d = HOLD;
            hold_d  = HOLD_INIT;
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - HOLD_ONE;
        if (hold_q <= HOLD_ONE) state_d = WAIT;
      end
      WAIT: begin
        if (!rndr_busy_i) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase
  end

  // State, issued command and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= ISSUE;
      hold_q      <= '0;
      cmd_o       <= '0;
      cmd_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cmd_valid_o <= pop;
      if (pop) cmd_o <= head;
      if (drop) overflow_o <= 1'b1;
      else if (clr_ovf_i) overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prim_cmd_queue.sv
// Self-checking bench for prim_cmd_queue: directed scenarios
// plus randomized traffic against a queue-based reference.
module tb_prim_cmd_queue;
  import xv::*;

  localparam int HOLD = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        wr_cmd_i = 1'b0;
  logic [15:0] wr_data_i = '0;
  logic        full_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic        clr_ovf_i = 1'b0;
  logic [15:0] cmd_o;
  logic        cmd_valid_o;
  logic        rndr_busy_i = 1'b0;
  logic        vram_grant_i = 1'b0;
  logic        rndr_oe_o;
  logic        idle_o;

  int n_pass = 0;
  int n_total = 0;

  prim_cmd_queue #(.DEPTH_LOG2(4), .HOLD_CYC(HOLD)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .wr_cmd_i     (wr_cmd_i),
    .wr_data_i    (wr_data_i),
    .full_o       (full_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .clr_ovf_i    (clr_ovf_i),
    .cmd_o        (cmd_o),
    .cmd_valid_o  (cmd_valid_o),
    .rndr_busy_i  (rndr_busy_i),
    .vram_grant_i (vram_grant_i),
    .rndr_oe_o    (rndr_oe_o),
    .idle_o       (idle_o)
  );

  always #5 clk = ~clk;

  // Reference: a plain queue of pending commands, plus a
  // "blocked" flag raised by an execute and released the
  // first cycle busy is low once HOLD cycles have elapsed.
  logic [15:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cmd = '0;
  bit          m_block = 1'b0;
  int          m_rel = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    bit pop;
    bit drop;
    logic [15:0] h;
    cyc = cyc + 1;
    if (reset_i) begin
      mq.delete();
      m_ovf = 1'b0;
      m_valid = 1'b0;
      m_cmd = '0;
      m_block = 1'b0;
    end else begin
      pop = !m_block && mq.size() > 0 && !rndr_busy_i;
      m_valid = pop;
      if (pop) begin
        h = mq.pop_front();
        m_cmd = h;
        if (h[15:12] == PR_EXECUTE) begin
          m_block = 1'b1;
          m_rel = cyc + HOLD + 1;
        end
      end else if (m_block && cyc >= m_rel && !rndr_busy_i) begin
        m_block = 1'b0;
      end
      drop = wr_cmd_i && mq.size() >= DEPTH;
      if (wr_cmd_i && !drop) mq.push_back(wr_data_i);
      if (drop) m_ovf = 1'b1;
      else if (clr_ovf_i) m_ovf = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    n_total++;
    if (count_o !== 5'd0) $display("FAIL rst_count got %0d want 0", count_o);
    else n_pass++;
    n_total++;
    if (full_o !== 1'b0) $display("FAIL rst_full got %b want 0", full_o);
    else n_pass++;
    n_total++;
    if (overflow_o !== 1'b0) $display("FAIL rst_ovf got %b want 0", overflow_o);
    else n_pass++;
    n_total++;
    if (cmd_valid_o !== 1'b0) $display("FAIL rst_valid got %b want 0", cmd_valid_o);
    else n_pass++;
    n_total++;
    if (cmd_o !== 16'h0000) $display("FAIL rst_cmd got %h want 0000", cmd_o);
    else n_pass++;
    n_total++;
    if (idle_o !== 1'b1) $display("FAIL rst_idle got %b want 1", idle_o);
    else n_pass++;
  endtask

  task automatic test_latency;
    wr_cmd_i = 1'b1;
    wr_data_i = 16'h1005;
    tick();
    wr_cmd_i = 1'b0;
    n_total++;
    if (cmd_valid_o !== 1'b0 || idle_o !== 1'b0)
      $display("FAIL lat_c1 got v=%b i=%b want v=0 i=0", cmd_valid_o, idle_o);
    else n_pass++;
    tick();
    n_total++;
    if (cmd_valid_o !== 1'b1 || cmd_o !== 16'h1005)
      $display("FAIL lat_c2 got v=%b cmd=%h want v=1 cmd=1005", cmd_valid_o, cmd_o);
    else n_pass++;
    tick();
    n_total++;
    if (cmd_valid_o !== 1'b0 || idle_o !== 1'b1)
      $display("FAIL lat_c3 got v=%b i=%b want v=0 i=1", cmd_valid_o, idle_o);
    else n_pass++;
  endtask

  task automatic test_execute;
    logic [15:0] exe;
    bit got;
    bit bad;
    exe = {PR_EXECUTE, 12'h003};
    got = 1'b0;
    bad = 1'b0;
    rndr_busy_i = 1'b0;
    wr_cmd_i = 1'b1;
    wr_data_i = 16'h1010;
    tick();
    wr_data_i = 16'h2020;
    tick();
    wr_data_i = exe;
    tick();
    wr_cmd_i = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (cmd_valid_o && cmd_o == exe) got = 1'b1;
    end
    n_total++;
    if (!got) $display("FAIL exe_issue got none want %h within 8 cycles", exe);
    else n_pass++;
    rndr_busy_i = 1'b1;
    wr_cmd_i = 1'b1;
    wr_data_i = 16'h1030;
    tick();
    wr_cmd_i = 1'b0;
    if (cmd_valid_o) bad = 1'b1;
    for (int i = 0; i < 49; i++) begin
      tick();
      if (cmd_valid_o) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL exe_hold got issue want none while busy");
    else n_pass++;
    n_total++;
    if (count_o !== 5'd1 || idle_o !== 1'b0)
      $display("FAIL exe_pend got cnt=%0d i=%b want cnt=1 i=0", count_o, idle_o);
    else n_pass++;
    rndr_busy_i = 1'b0;
    tick();
    n_total++;
    if (cmd_valid_o !== 1'b0)
      $display("FAIL exe_fall got v=%b want 0", cmd_valid_o);
    else n_pass++;
    tick();
    n_total++;
    if (cmd_valid_o !== 1'b1 || cmd_o !== 16'h1030)
      $display("FAIL exe_after got v=%b cmd=%h want v=1 cmd=1030", cmd_valid_o, cmd_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_overflow;
    rndr_busy_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_cmd_i = 1'b1;
      wr_data_i = 16'h1000 + 16'(i);
      tick();
      if (i == 15) begin
        n_total++;
        if (full_o !== 1'b1 || count_o !== 5'd16 || overflow_o !== 1'b0)
          $display("FAIL ovf_16 got f=%b c=%0d o=%b want 1 16 0", full_o, count_o, overflow_o);
        else n_pass++;
      end
    end
    wr_cmd_i = 1'b0;
    n_total++;
    if (overflow_o !== 1'b1 || count_o !== 5'd16)
      $display("FAIL ovf_17 got o=%b c=%0d want o=1 c=16", overflow_o, count_o);
    else n_pass++;
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    n_total++;
    if (overflow_o !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow_o);
    else n_pass++;
  endtask

  task automatic test_full_pop;
    bit bad;
    bad = 1'b0;
    rndr_busy_i = 1'b0;
    wr_cmd_i = 1'b1;
    wr_data_i = 16'h3abc;
    tick();
    wr_cmd_i = 1'b0;
    n_total++;
    if (count_o !== 5'd16 || overflow_o !== 1'b0 || cmd_valid_o !== 1'b1 || cmd_o !== 16'h1000)
      $display("FAIL fullpop got c=%0d o=%b v=%b cmd=%h want 16 0 1 1000",
               count_o, overflow_o, cmd_valid_o, cmd_o);
    else n_pass++;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (cmd_valid_o !== 1'b1 || cmd_o !== 16'h1000 + 16'(i)) bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL drain_order got out-of-order want 1001..100f");
    else n_pass++;
    tick();
    n_total++;
    if (cmd_valid_o !== 1'b1 || cmd_o !== 16'h3abc)
      $display("FAIL drain_last got v=%b cmd=%h want v=1 cmd=3abc", cmd_valid_o, cmd_o);
    else n_pass++;
    tick();
    n_total++;
    if (count_o !== 5'd0 || idle_o !== 1'b1)
      $display("FAIL drain_end got c=%0d i=%b want c=0 i=1", count_o, idle_o);
    else n_pass++;
  endtask

  task automatic test_grant;
    bit pat[5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      vram_grant_i = pat[i];
      #1;
      n_total++;
      if (rndr_oe_o !== pat[i])
        $display("FAIL grant_%0d got %b want %b", i, rndr_oe_o, pat[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_wait;
    rndr_busy_i = 1'b0;
    wr_cmd_i = 1'b1;
    wr_data_i = {PR_EXECUTE, 12'h7ff};
    tick();
    wr_cmd_i = 1'b0;
    tick();
    rndr_busy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_cmd_i = 1'b1;
      wr_data_i = 16'h1100 + 16'(i);
      tick();
    end
    wr_cmd_i = 1'b0;
    tick();
    tick();
    n_total++;
    if (count_o !== 5'd5 || cmd_valid_o !== 1'b0)
      $display("FAIL rw_pre got c=%0d v=%b want c=5 v=0", count_o, cmd_valid_o);
    else n_pass++;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_total++;
    if (count_o !== 5'd0 || cmd_valid_o !== 1'b0 || idle_o !== 1'b0)
      $display("FAIL rw_post got c=%0d v=%b i=%b want 0 0 0", count_o, cmd_valid_o, idle_o);
    else n_pass++;
    rndr_busy_i = 1'b0;
    #1;
    n_total++;
    if (idle_o !== 1'b1) $display("FAIL rw_idle got %b want 1", idle_o);
    else n_pass++;
    tick();
  endtask

  task automatic test_random;
    int busy_pct;
    int errs;
    busy_pct = 10;
    errs = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 100 == 0) busy_pct = ($urandom_range(0, 2) == 0) ? 10 :
                                   ($urandom_range(0, 1) == 0) ? 50 : 90;
      reset_i = ($urandom_range(0, 199) == 0);
      wr_cmd_i = ($urandom_range(0, 99) < 60);
      wr_data_i[11:0] = 12'($urandom);
      wr_data_i[15:12] = ($urandom_range(0, 7) == 0) ? PR_EXECUTE : 4'($urandom);
      rndr_busy_i = ($urandom_range(0, 99) < busy_pct);
      clr_ovf_i = ($urandom_range(0, 19) == 0);
      vram_grant_i = 1'($urandom);
      #1;
      n_total++;
      if (idle_o !== (mq.size() == 0 && !m_block && !rndr_busy_i) || rndr_oe_o !== vram_grant_i) begin
        if (errs++ < 10)
          $display("FAIL rnd_comb@%0d got i=%b oe=%b want i=%b oe=%b", n, idle_o, rndr_oe_o,
                   (mq.size() == 0 && !m_block && !rndr_busy_i), vram_grant_i);
      end else n_pass++;
      tick();
      n_total++;
      if (count_o !== 5'(mq.size()) || full_o !== (mq.size() == DEPTH) ||
          overflow_o !== m_ovf || cmd_valid_o !== m_valid || cmd_o !== m_cmd) begin
        if (errs++ < 10)
          $display("FAIL rnd_seq@%0d got c=%0d f=%b o=%b v=%b cmd=%h want c=%0d f=%b o=%b v=%b cmd=%h",
                   n, count_o, full_o, overflow_o, cmd_valid_o, cmd_o,
                   mq.size(), (mq.size() == DEPTH), m_ovf, m_valid, m_cmd);
      end else n_pass++;
    end
    reset_i = 1'b0;
    wr_cmd_i = 1'b0;
    clr_ovf_i = 1'b0;
    rndr_busy_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_execute();
    test_overflow();
    test_full_pop();
    test_grant();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
